// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory port around memory_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory side.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  fetchReq;
    logic [ADDR_WIDTH-1:0] fetchAddress;
    logic                  fetchReady;
    logic                  fetchValid;
    logic [DATA_WIDTH-1:0] fetchData;

    logic                  dataReq;
    logic                  dataWrite;
    logic [ADDR_WIDTH-1:0] dataAddress;
    logic [DATA_WIDTH-1:0] dataWriteData;
    logic                  dataReady;
    logic                  dataValid;
    logic [DATA_WIDTH-1:0] dataReadData;

    logic                  memEnable;
    logic                  memWriteEnable;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic [DATA_WIDTH-1:0] memReadData;

    modport slave (
        input  fetchReq, fetchAddress,
        input  dataReq, dataWrite, dataAddress, dataWriteData,
        input  memReadData,
        output fetchReady, fetchValid, fetchData,
        output dataReady, dataValid, dataReadData,
        output memEnable, memWriteEnable, memAddress, memWriteData
    );

    modport master (
        output fetchReq, fetchAddress,
        output dataReq, dataWrite, dataAddress, dataWriteData,
        output memReadData,
        input  fetchReady, fetchValid, fetchData,
        input  dataReady, dataValid, dataReadData,
        input  memEnable, memWriteEnable, memAddress, memWriteData
    );
endinterface

// File: rtl/memory_arbiter.sv
// Serializes instruction fetch and load/store onto one synchronous memory port,
// routing each 1-cycle-latency read response back to the requester that issued it.
//
//   state | meaning
//   FETCH | last grant went to fetch (reset value); round-robin conflict goes to data
//   DATA  | last grant went to load/store; round-robin conflict goes to fetch
module memory_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_PRIORITY  = 0,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    memory_arbiter_if.slave   bus
);
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} grant_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);

    grant_t     last_grant, last_grant_nxt;
    logic [3:0] burst_count, burst_count_nxt;
    logic       grant_fetch, grant_data;
    logic       fetch_pend, data_pend, store_pend;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant  <= FETCH;
            burst_count <= 4'd0;
            fetch_pend  <= 1'b0;
            data_pend   <= 1'b0;
            store_pend  <= 1'b0;
        end else begin
            last_grant  <= last_grant_nxt;
            burst_count <= burst_count_nxt;
            fetch_pend  <= grant_fetch;
            data_pend   <= grant_data;
            store_pend  <= grant_data & bus.dataWrite;
        end
    end

    // burst_count only survives cycles where data wins while fetch is waiting
    always_comb begin
        grant_fetch     = 1'b0;
        grant_data      = 1'b0;
        last_grant_nxt  = last_grant;
        burst_count_nxt = 4'd0;
        if (!reset) begin
            if (bus.fetchReq && bus.dataReq) begin
                if (DATA_PRIORITY == 0) begin
                    if (last_grant == FETCH) grant_data  = 1'b1;
                    else                     grant_fetch = 1'b1;
                end else if (burst_count < BURST_LIMIT) begin
                    grant_data      = 1'b1;
                    burst_count_nxt = burst_count + 4'd1;
                end else begin
                    grant_fetch = 1'b1;
                end
            end else if (bus.fetchReq) begin
                grant_fetch = 1'b1;
            end else if (bus.dataReq) begin
                grant_data = 1'b1;
            end
            if (grant_fetch)     last_grant_nxt = FETCH;
            else if (grant_data) last_grant_nxt = DATA;
        end
    end

    assign bus.fetchReady     = grant_fetch;
    assign bus.dataReady      = grant_data;
    assign bus.memEnable      = grant_fetch | grant_data;
    assign bus.memWriteEnable = grant_data & bus.dataWrite;
    assign bus.memAddress     = grant_data  ? bus.dataAddress  :
                                grant_fetch ? bus.fetchAddress : {ADDR_WIDTH{1'b0}};
    assign bus.memWriteData   = (grant_data && bus.dataWrite) ? bus.dataWriteData
                                                              : {DATA_WIDTH{1'b0}};

    // responses registered before a reset are masked while reset is held
    assign bus.fetchValid   = fetch_pend & ~reset;
    assign bus.dataValid    = data_pend & ~reset;
    assign bus.fetchData    = bus.fetchValid ? bus.memReadData : {DATA_WIDTH{1'b0}};
    assign bus.dataReadData = (bus.dataValid && !store_pend) ? bus.memReadData
                                                             : {DATA_WIDTH{1'b0}};
endmodule

// File: tb/tb_memory_arbiter.sv
// Drives a round-robin and a data-priority arbiter side by side, each with its own memory,
// and compares every output each cycle against a transaction-level reference model.
module tb_memory_arbiter;
    logic clock = 1'b0;
    logic reset;
    logic mem_init;

    always #5 clock = ~clock;

    memory_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) ifr ();
    memory_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) ifp ();

    memory_arbiter #(.DATA_PRIORITY(0), .MAX_DATA_BURST(4)) dut_rr (
        .clock(clock), .reset(reset), .bus(ifr));
    memory_arbiter #(.DATA_PRIORITY(1), .MAX_DATA_BURST(4)) dut_pr (
        .clock(clock), .reset(reset), .bus(ifp));

    logic        f_req [2];
    logic [7:0]  f_addr[2];
    logic        d_req [2];
    logic        d_wr  [2];
    logic [7:0]  d_addr[2];
    logic [15:0] d_wd  [2];

    assign ifr.fetchReq = f_req[0];  assign ifp.fetchReq = f_req[1];
    assign ifr.fetchAddress = f_addr[0];  assign ifp.fetchAddress = f_addr[1];
    assign ifr.dataReq = d_req[0];  assign ifp.dataReq = d_req[1];
    assign ifr.dataWrite = d_wr[0];  assign ifp.dataWrite = d_wr[1];
    assign ifr.dataAddress = d_addr[0];  assign ifp.dataAddress = d_addr[1];
    assign ifr.dataWriteData = d_wd[0];  assign ifp.dataWriteData = d_wd[1];

    logic        o_fr[2], o_dr[2], o_fv[2], o_dv[2], o_me[2], o_mwe[2];
    logic [15:0] o_fd[2], o_drd[2], o_mwd[2];
    logic [7:0]  o_ma[2];

    assign o_fr[0] = ifr.fetchReady;  assign o_fr[1] = ifp.fetchReady;
    assign o_dr[0] = ifr.dataReady;  assign o_dr[1] = ifp.dataReady;
    assign o_fv[0] = ifr.fetchValid;  assign o_fv[1] = ifp.fetchValid;
    assign o_dv[0] = ifr.dataValid;  assign o_dv[1] = ifp.dataValid;
    assign o_fd[0] = ifr.fetchData;  assign o_fd[1] = ifp.fetchData;
    assign o_drd[0] = ifr.dataReadData;  assign o_drd[1] = ifp.dataReadData;
    assign o_me[0] = ifr.memEnable;  assign o_me[1] = ifp.memEnable;
    assign o_mwe[0] = ifr.memWriteEnable;  assign o_mwe[1] = ifp.memWriteEnable;
    assign o_ma[0] = ifr.memAddress;  assign o_ma[1] = ifp.memAddress;
    assign o_mwd[0] = ifr.memWriteData;  assign o_mwd[1] = ifp.memWriteData;

    function automatic logic [15:0] init_word(input int a);
        return (a == 12) ? 16'h2231 : 16'(16'h1000 + a);
    endfunction

    // Behavioural 256x16 synchronous memories, one per arbiter
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    always @(posedge clock) begin
        if (mem_init) begin
            for (int a = 0; a < 256; a++) begin
                mem0[a] <= init_word(a);
                mem1[a] <= init_word(a);
            end
        end else begin
            if (ifr.memEnable) begin
                if (ifr.memWriteEnable) mem0[ifr.memAddress] <= ifr.memWriteData;
                ifr.memReadData <= mem0[ifr.memAddress];
            end
            if (ifp.memEnable) begin
                if (ifp.memWriteEnable) mem1[ifp.memAddress] <= ifp.memWriteData;
                ifp.memReadData <= mem1[ifp.memAddress];
            end
        end
    end

    // Reference model state
    logic [15:0] ref_mem [2][256];
    int          pend_kind [2];      // 0 none, 1 fetch response, 2 data response
    logic [15:0] pend_data [2];
    logic        last_was_data [2];
    int          data_run [2];       // consecutive data wins while fetch waited
    logic        acc_f [2], acc_d [2];
    int          grant_obs [2];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input int d, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", tag, d, $time, got, exp);
        end
    endtask

    // Called right after a falling edge with inputs driven; checks and advances one cycle.
    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [7:0]  ea;
            logic [15:0] ewd;
            logic        efv, edv;
            g = 0;
            if (!reset) begin
                if (f_req[d] && d_req[d]) begin
                    if (d == 0)            g = last_was_data[d] ? 1 : 2;
                    else if (data_run[d] < 4) g = 2;
                    else                   g = 1;
                end else if (f_req[d]) g = 1;
                else if (d_req[d])     g = 2;
            end
            ea  = (g == 1) ? f_addr[d] : (g == 2) ? d_addr[d] : 8'h00;
            ewd = (g == 2 && d_wr[d]) ? d_wd[d] : 16'h0000;
            efv = !reset && pend_kind[d] == 1;
            edv = !reset && pend_kind[d] == 2;

            check("fetchReady",     d, 32'(o_fr[d]),  32'(g == 1));
            check("dataReady",      d, 32'(o_dr[d]),  32'(g == 2));
            check("memEnable",      d, 32'(o_me[d]),  32'(g != 0));
            check("memWriteEnable", d, 32'(o_mwe[d]), 32'(g == 2 && d_wr[d]));
            check("memAddress",     d, 32'(o_ma[d]),  32'(ea));
            check("memWriteData",   d, 32'(o_mwd[d]), 32'(ewd));
            check("fetchValid",     d, 32'(o_fv[d]),  32'(efv));
            check("fetchData",      d, 32'(o_fd[d]),  32'(efv ? pend_data[d] : 16'h0000));
            check("dataValid",      d, 32'(o_dv[d]),  32'(edv));
            check("dataReadData",   d, 32'(o_drd[d]), 32'(edv ? pend_data[d] : 16'h0000));

            grant_obs[d] = o_fr[d] ? 1 : o_dr[d] ? 2 : 0;
            acc_f[d] = (g == 1);
            acc_d[d] = (g == 2);
            if (reset) begin
                pend_kind[d]     = 0;
                last_was_data[d] = 1'b0;
                data_run[d]      = 0;
            end else begin
                pend_kind[d] = g;
                pend_data[d] = (g == 1) ? ref_mem[d][f_addr[d]] :
                               (g == 2 && !d_wr[d]) ? ref_mem[d][d_addr[d]] : 16'h0000;
                if (g == 2 && d_wr[d]) ref_mem[d][d_addr[d]] = d_wd[d];
                if (g != 0) last_was_data[d] = (g == 2);
                data_run[d] = (g == 2 && f_req[d]) ? data_run[d] + 1 : 0;
            end
        end
        @(negedge clock);
    endtask

    // New random request only once the previous one was accepted (or none was pending)
    task automatic gen_random(input int d);
        if (!f_req[d] || acc_f[d]) begin
            f_req[d]  = ($urandom_range(3) != 0);
            f_addr[d] = 8'($urandom_range(255));
        end
        if (!d_req[d] || acc_d[d]) begin
            d_req[d]  = ($urandom_range(3) != 0);
            d_wr[d]   = 1'($urandom_range(1));
            d_addr[d] = 8'($urandom_range(15));
            d_wd[d]   = 16'($urandom);
        end
    endtask

    task automatic set_all(input logic fr, input logic [7:0] fa, input logic dr,
                           input logic dw, input logic [7:0] da, input logic [15:0] dd);
        for (int d = 0; d < 2; d++) begin
            f_req[d] = fr;  f_addr[d] = fa;
            d_req[d] = dr;  d_wr[d] = dw;  d_addr[d] = da;  d_wd[d] = dd;
        end
    endtask

    int rr_seq [10];
    int pr_seq [10];

    initial begin
        rr_seq = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
        pr_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        reset    = 1'b1;
        mem_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) ref_mem[d][a] = init_word(a);
            pend_kind[d] = 0;  pend_data[d] = 16'h0;
            last_was_data[d] = 1'b0;  data_run[d] = 0;
            acc_f[d] = 1'b0;  acc_d[d] = 1'b0;  grant_obs[d] = 0;
        end
        set_all(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clock);
        @(negedge clock);
        mem_init = 1'b0;
        tick();
        // reset held while requests are present: nothing may be granted
        set_all(1'b1, 8'h01, 1'b1, 1'b1, 8'h02, 16'h5555);
        tick();
        set_all(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        reset = 1'b0;

        // fetch-only stream
        for (int i = 0; i < 5; i++) begin
            set_all(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 16'h0000);
            tick();
        end
        set_all(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        check("fetch_last_word", 0, 32'(ref_mem[0][4]), 32'h1004);

        // store then load of the same address
        set_all(1'b0, 8'h00, 1'b1, 1'b1, 8'h0F, 16'hFA2D);
        tick();
        set_all(1'b0, 8'h00, 1'b1, 1'b0, 8'h0F, 16'h0000);
        tick();
        set_all(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1;
        check("store_load_data", 0, 32'(o_drd[0]), 32'hFA2D);
        check("store_load_data", 1, 32'(o_drd[1]), 32'hFA2D);
        tick();

        // sustained conflict straight after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_all(1'b1, 8'h20, 1'b1, 1'b0, 8'h21, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rr_grant_seq", 0, 32'(grant_obs[0]), 32'(rr_seq[i]));
            check("pr_grant_seq", 1, 32'(grant_obs[1]), 32'(pr_seq[i]));
        end
        set_all(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        tick();

        // reset discards an in-flight load; the reload still returns the stored word
        set_all(1'b0, 8'h00, 1'b1, 1'b0, 8'h0C, 16'h0000);
        tick();
        set_all(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        set_all(1'b0, 8'h00, 1'b1, 1'b0, 8'h0C, 16'h0000);
        tick();
        set_all(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1;
        check("reload_after_reset", 0, 32'(o_drd[0]), 32'h2231);
        check("reload_after_reset", 1, 32'(o_drd[1]), 32'h2231);
        tick();

        // idle
        for (int i = 0; i < 3; i++) tick();

        // random protocol-compliant traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            gen_random(0);
            gen_random(1);
            reset = ($urandom_range(59) == 0);
            tick();
        end
        reset = 1'b0;
        set_all(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
